// File: rtl/matrix_readout_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matrix_readout_scheduler
// Purpose  : Walks the Double_Buffer read port column by column into the
//            output stage; swaps banks only between frames, else replays.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_readout_scheduler #(
    parameter int ADDRESS_DEPTH    = 480,
    parameter int COLUMN_COUNT     = 16,
    parameter int WORDS_PER_COLUMN = 30,
    parameter int READ_LATENCY     = 2,
    parameter int FRAME_GAP        = 1000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             data_valid,
    output logic                             swap_trigger,
    output logic [$clog2(ADDRESS_DEPTH)-1:0] buf_addr,
    output logic                             buf_rd_en,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic                             word_last,
    output logic                             new_image,
    output logic                             new_column,
    output logic [$clog2(COLUMN_COUNT)-1:0]  column_index,
    input  logic                             col_done,
    output logic                             busy
);

    localparam int c_ADDR_W = $clog2(ADDRESS_DEPTH);
    localparam int c_COL_W  = $clog2(COLUMN_COUNT);
    localparam int c_WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
    localparam int c_GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int c_LAT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    localparam logic [c_GAP_W-1:0]  c_GAP_RELOAD = c_GAP_W'(FRAME_GAP - 1);
    localparam logic [c_WORD_W-1:0] c_WORD_LAST  = c_WORD_W'(WORDS_PER_COLUMN - 1);
    localparam logic [c_COL_W-1:0]  c_COL_LAST   = c_COL_W'(COLUMN_COUNT - 1);
    localparam logic [c_ADDR_W-1:0] c_COL_STEP   = c_ADDR_W'(WORDS_PER_COLUMN);
    localparam logic [c_LAT_W-1:0]  c_LAT_RELOAD = c_LAT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SWAP        = 3'd1,
        S_FRAME_START = 3'd2,
        S_COL_START   = 3'd3,
        S_READ        = 3'd4,
        S_LAT         = 3'd5,
        S_HOLD        = 3'd6,
        S_WAIT_TX     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [c_LAT_W-1:0]  r_lat_cnt;
    logic [c_WORD_W-1:0] r_word_cnt;
    logic [c_COL_W-1:0]  r_col_idx;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_ADDR_W-1:0] r_col_base;
    logic                w_last_word;
    logic                w_last_col;

    assign w_last_word = (r_word_cnt == c_WORD_LAST);
    assign w_last_col  = (r_col_idx == c_COL_LAST);

    always_comb begin
        w_next       = r_state;
        swap_trigger = 1'b0;
        buf_rd_en    = 1'b0;
        word_valid   = 1'b0;
        word_last    = 1'b0;
        new_image    = 1'b0;
        new_column   = 1'b0;
        buf_addr     = r_addr;
        column_index = r_col_idx;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (r_gap_cnt == '0) begin
                    w_next = data_valid ? S_SWAP : S_FRAME_START;
                end
            end
            S_SWAP: begin
                swap_trigger = 1'b1;
                w_next       = S_FRAME_START;
            end
            S_FRAME_START: begin
                new_image = 1'b1;
                w_next    = S_COL_START;
            end
            S_COL_START: begin
                new_column = 1'b1;
                w_next     = S_READ;
            end
            S_READ: begin
                buf_rd_en = 1'b1;
                w_next    = (READ_LATENCY > 1) ? S_LAT : S_HOLD;
            end
            S_LAT: begin
                if (r_lat_cnt == '0) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                word_valid = 1'b1;
                word_last  = w_last_word;
                if (word_ready) begin
                    w_next = w_last_word ? S_WAIT_TX : S_READ;
                end
            end
            S_WAIT_TX: begin
                if (col_done) begin
                    w_next = w_last_col ? S_IDLE : S_COL_START;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Column base address advances by one column stride instead of multiplying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gap_cnt  <= c_GAP_RELOAD;
            r_lat_cnt  <= '0;
            r_word_cnt <= '0;
            r_col_idx  <= '0;
            r_addr     <= '0;
            r_col_base <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next == S_IDLE) && (r_state != S_IDLE)) begin
                r_gap_cnt <= c_GAP_RELOAD;
            end else if ((r_state == S_IDLE) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
            end
            case (r_state)
                S_FRAME_START: begin
                    r_col_idx  <= '0;
                    r_col_base <= '0;
                end
                S_COL_START: begin
                    r_word_cnt <= '0;
                    r_addr     <= r_col_base;
                end
                S_READ: r_lat_cnt <= c_LAT_RELOAD;
                S_LAT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (word_ready && !w_last_word) begin
                        r_word_cnt <= r_word_cnt + c_WORD_W'(1);
                        r_addr     <= r_addr + c_ADDR_W'(1);
                    end
                end
                S_WAIT_TX: begin
                    if (col_done && !w_last_col) begin
                        r_col_idx  <= r_col_idx + c_COL_W'(1);
                        r_col_base <= r_col_base + c_COL_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_readout_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_readout_scheduler
// Purpose  : Directed self-checking bench for matrix_readout_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_readout_scheduler;

    localparam int ADDRESS_DEPTH    = 8;
    localparam int COLUMN_COUNT     = 2;
    localparam int WORDS_PER_COLUMN = 3;
    localparam int READ_LATENCY     = 2;
    localparam int FRAME_GAP        = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       data_valid = 1'b0;
    logic       word_ready = 1'b0;
    logic       col_done;
    logic       swap_trigger, buf_rd_en, word_valid, word_last;
    logic       new_image, new_column, busy;
    logic [2:0] buf_addr;
    logic [0:0] column_index;

    logic auto_pulse = 1'b0;
    logic man_pulse  = 1'b0;
    bit   auto_done  = 1'b1;
    assign col_done = auto_pulse | man_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int clr_seq = 0;

    // Event log, owned by the recorder process only.
    int   rd_addr_q[$], rd_cyc_q[$], vr_cyc_q[$], acc_addr_q[$], acc_col_q[$], acc_last_q[$];
    int   swap_cnt = 0, img_cnt = 0, col_cnt = 0, seen_seq = 0;
    logic prev_valid = 1'b0;

    matrix_readout_scheduler #(
        .ADDRESS_DEPTH   (ADDRESS_DEPTH),
        .COLUMN_COUNT    (COLUMN_COUNT),
        .WORDS_PER_COLUMN(WORDS_PER_COLUMN),
        .READ_LATENCY    (READ_LATENCY),
        .FRAME_GAP       (FRAME_GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_valid  (data_valid),
        .swap_trigger(swap_trigger),
        .buf_addr    (buf_addr),
        .buf_rd_en   (buf_rd_en),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_last   (word_last),
        .new_image   (new_image),
        .new_column  (new_column),
        .column_index(column_index),
        .col_done    (col_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #2;
        if (seen_seq != clr_seq) begin
            seen_seq = clr_seq;
            rd_addr_q.delete(); rd_cyc_q.delete(); vr_cyc_q.delete();
            acc_addr_q.delete(); acc_col_q.delete(); acc_last_q.delete();
            swap_cnt = 0; img_cnt = 0; col_cnt = 0;
        end
        if (buf_rd_en) begin
            rd_addr_q.push_back(int'(buf_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (word_valid && !prev_valid) vr_cyc_q.push_back(cyc);
        if (word_valid && word_ready) begin
            acc_addr_q.push_back(int'(buf_addr));
            acc_col_q.push_back(int'(column_index));
            acc_last_q.push_back(int'(word_last));
        end
        if (swap_trigger) swap_cnt++;
        if (new_image)    img_cnt++;
        if (new_column)   col_cnt++;
        prev_valid = word_valid;
    end

    // Output-stage model: finishes the column 5 cycles after its last word.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_done && word_valid && word_ready && word_last) begin
                repeat (5) @(negedge clk);
                auto_pulse = 1'b1;
                @(negedge clk);
                auto_pulse = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int kind, input int addr);
        case (kind)
            0: return busy;
            1: return !busy;
            2: return swap_trigger;
            3: return new_image;
            4: return buf_rd_en && (int'(buf_addr) == addr);
            5: return word_valid;
            6: return word_valid && word_last;
            7: return word_valid && (int'(buf_addr) == addr);
            8: return buf_rd_en;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_on(input string tag, input int kind, input int addr);
        int n = 0;
        while (!cond(kind, addr) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(cond(kind, addr)), 1);
    endtask

    task automatic clr_logs();
        clr_seq++;
        @(negedge clk);
    endtask

    initial begin
        int t0, ok, sc;

        // Reset and nominal frame with a swap
        data_valid = 1'b1;
        word_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {25'd0, swap_trigger, buf_rd_en, word_valid, word_last,
                         new_image, new_column, busy}, 0);
        chk("rst_addr", buf_addr, 0);
        chk("rst_col", column_index, 0);
        rst_n = 1'b1;
        t0 = cyc;
        wait_on("t1_swap", 2, 0);
        chk("t1_swap_delay", cyc - t0, 4);
        data_valid = 1'b0;
        @(negedge clk);
        chk("t1_img", new_image, 1);
        @(negedge clk);
        chk("t1_newcol", new_column, 1);
        chk("t1_col0", column_index, 0);
        wait_on("t1_end", 1, 0);
        chk("t1_swap_cnt", swap_cnt, 1);
        chk("t1_img_cnt", img_cnt, 1);
        chk("t1_col_cnt", col_cnt, 2);
        chk("t1_rd_cnt", rd_addr_q.size(), 6);
        chk("t1_vr_cnt", vr_cyc_q.size(), 6);
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            chk("t1_addr", rd_addr_q[i], i);
            if (i < vr_cyc_q.size()) chk("t1_latency", vr_cyc_q[i] - rd_cyc_q[i], READ_LATENCY);
        end
        chk("t1_acc_cnt", acc_addr_q.size(), 6);
        for (int i = 0; i < acc_addr_q.size(); i++) begin
            chk("t1_acc_col", acc_col_q[i], i / 3);
            chk("t1_acc_last", acc_last_q[i], (i % 3 == 2) ? 1 : 0);
        end

        // Three replayed frames without new data
        clr_logs();
        for (int f = 0; f < 3; f++) begin
            wait_on("t2_start", 0, 0);
            wait_on("t2_end", 1, 0);
        end
        chk("t2_swap_cnt", swap_cnt, 0);
        chk("t2_img_cnt", img_cnt, 3);
        chk("t2_rd_cnt", rd_addr_q.size(), 18);
        for (int i = 0; i < rd_addr_q.size(); i++) chk("t2_addr", rd_addr_q[i], i % 6);

        // Backpressure on address 1
        clr_logs();
        wait_on("t3_rd1", 4, 1);
        word_ready = 1'b0;
        wait_on("t3_valid", 5, 0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (word_valid && !buf_rd_en && buf_addr == 3'd1) ok++;
            @(negedge clk);
        end
        chk("t3_hold", ok, 10);
        word_ready = 1'b1;
        wait_on("t3_end", 1, 0);
        chk("t3_rd_cnt", rd_addr_q.size(), 6);
        for (int i = 0; i < rd_addr_q.size(); i++) chk("t3_addr", rd_addr_q[i], i);
        chk("t3_acc_cnt", acc_addr_q.size(), 6);

        // data_valid rising mid-frame waits for the frame boundary
        clr_logs();
        wait_on("t4_rd0", 4, 0);
        data_valid = 1'b1;
        wait_on("t4_end", 1, 0);
        chk("t4_no_swap", swap_cnt, 0);
        t0 = cyc;
        wait_on("t4_swap", 2, 0);
        chk("t4_swap_delay", cyc - t0, FRAME_GAP);
        data_valid = 1'b0;
        @(negedge clk);
        chk("t4_img", new_image, 1);
        auto_done = 1'b0;

        // col_done during HOLD is ignored
        wait_on("t5_last", 6, 0);
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy && !new_column && !buf_rd_en && !word_valid && column_index == 1'b0) ok++;
            @(negedge clk);
        end
        chk("t5_wait_tx", ok, 20);
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        chk("t5_newcol", new_column, 1);
        chk("t5_col1", column_index, 1);
        auto_done = 1'b1;
        wait_on("t5_end", 1, 0);

        // Asynchronous reset in HOLD on address 4
        data_valid = 1'b1;
        wait_on("t6_hold4", 7, 4);
        sc = swap_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6_async_ctrl", {25'd0, swap_trigger, buf_rd_en, word_valid, word_last,
                              new_image, new_column, busy}, 0);
        chk("t6_async_addr", buf_addr, 0);
        chk("t6_async_col", column_index, 0);
        repeat (2) @(negedge clk);
        chk("t6_no_swap", swap_cnt, sc);
        rst_n = 1'b1;
        t0 = cyc;
        wait_on("t6_img", 3, 0);
        chk("t6_img_delay", cyc - t0, FRAME_GAP + 1);
        chk("t6_swap_cnt", swap_cnt, sc + 1);
        data_valid = 1'b0;
        wait_on("t6_rd", 8, 0);
        chk("t6_first_addr", buf_addr, 0);
        wait_on("t6_end", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
